tec8_datapath: RTL
==================

Name: tec8_datapath

Overview:
- Executes the control word from the hardwired TEC-8 controller. It holds the register file, PC, AR, IR, the C/Z flags, a 74181-style ALU and the internal data bus (DBUS).
- Returns IR[7:4], C and Z to the controller, closing the controller↔datapath loop.
- Connects to an instruction read port (addressed by PC) and a data read/write port (addressed by AR).
- State updates on each T3 rising edge. The controller sequences on T3 falling edges, so control is stable half a cycle before it is consumed.

Parameters:
- DW, 8, datapath/address width (PC, AR, registers, buses).
- NREG, 4, register count; register index is 2 bits, so NREG=4 is the only legal value.

Ports:
- T3  in  1  clock; all state updates on rising edge.
- CLR  in  1  asynchronous active-low reset.
- SEL  in  4  manual register select: [3:2] = RD/A index, [1:0] = RS/B index.
- SELCTL  in  1  1 = use SEL; 0 = use IR[3:2] / IR[1:0].
- S  in  4  ALU function select.
- M  in  1  1 = logic mode, 0 = arithmetic mode.
- CIN  in  1  active-low carry-in: 0 adds +1.
- ABUS, SBUS, MBUS  in  1 each  DBUS source enables: ALU F, switch data SD, D_RDATA.
- DRW  in  1  write DBUS into R[RD].
- LPC, PCINC, PCADD  in  1 each  PC controls.
- LAR, ARINC  in  1 each  AR controls.
- LIR  in  1  load IR from I_RDATA.
- LDC, LDZ  in  1 each  flag loads.
- MEMW  in  1  data memory write.
- SD  in  DW  front-panel switch data.
- I_RDATA  in  DW  instruction read data (combinational from I_ADDR).
- D_RDATA  in  DW  data read data (combinational from D_ADDR).
- IR  out  4  IR[7:4] to controller.
- C, Z  out  1 each  flags.
- I_ADDR  out  DW  equals PC.
- D_ADDR  out  DW  equals AR.
- D_WDATA  out  DW  equals DBUS.
- D_WE  out  1  equals MEMW.
- DBUS  out  DW  debug / display of the bus.
- PC_Q, AR_Q  out  DW each  debug.
- REGS  out  4*DW  {R3,R2,R1,R0}.
- BUS_ERR  out  1  sticky bus-conflict flag.

Behaviour:
- Reset: CLR low asynchronously clears PC, AR, IR (8-bit internal), R0..R3, C, Z and BUS_ERR to 0.
- Register select: RD = SELCTL ? SEL[3:2] : IR[3:2]; RS = SELCTL ? SEL[1:0] : IR[1:0]. ALU A = R[RD], B = R[RS].
- ALU, M=1 (logic, standard 74181 active-high table). Required codes:
  - 0000 ~A, 0110 A^B, 1010 B, 1011 A&B, 1110 A|B, 1111 A.
  - Logic-mode carry_out = current C, so LDC in logic mode (e.g. JMP) leaves C unchanged.
- ALU, M=0 (arithmetic), with cin = ~CIN; all other codes per 74181. Required codes:
  - 0000 A+cin.
  - 0110 A+~B+cin (A-B when CIN=0).
  - 1001 A+B+cin.
  - 1111 A-1+cin.
  - carry_out = bit DW of the (DW+1)-bit sum. For subtract, C=1 means no borrow.
- DBUS priority: MBUS > ABUS > SBUS. No source enabled → DBUS = 0.
- BUS_ERR: set on any rising edge where more than one of ABUS/SBUS/MBUS is high; held until CLR.
- Register file: DRW writes DBUS to R[RD] on the edge.
- PC: LPC → DBUS (highest priority). Else PC + (PCADD ? sext(IR[3:0]) : 0) + PCINC. Wraps modulo 2^DW.
- AR: LAR → DBUS; else ARINC → AR+1 (wraps). LAR wins over ARINC.
- IR: LIR → I_RDATA. Same-edge LIR with MEMW, LPC or DRW is legal; every old value read within the cycle is pre-edge.
- Flags: LDC → C = carry_out; LDZ → Z = (F == 0), evaluated on ALU F regardless of whether ABUS is set.
- Memory: D_WE = MEMW combinationally. The write commits externally on the T3 rising edge. I_ADDR and D_ADDR always reflect current PC and AR.
- Controller-only signals (STOP, SHORT, LONG) are not inputs.

Decomposition:
- Package tec8_pkg:
  - DW constant.
  - ALU S-code constants: S_ADD=1001, S_SUB=0110, S_PASSB=1010, S_AND=1011, S_OR=1110, S_XOR=0110, S_PASSA=1111.
  - DBUS source priority order.
- One sub-module tec8_alu181 (combinational: A, B, S, M, CIN, C_in → F, carry_out). Registers and buses stay in the top.

Test Plan:
- CLR low mid-run with PC=0x33 → PC, AR, IR, R0..R3, C, Z, BUS_ERR all read 0 immediately, before any T3 edge.
- SELCTL=1, SEL=1100, SBUS=1, SD=0x5A, DRW=1, one edge → R3=0x5A; REGS=0x5A000000.
- IR=0x11, R0=0xF0, R1=0x20, S=1001, M=0, CIN=1, ABUS, DRW, LDC, LDZ → R0=0x10, C=1, Z=0.
- R2=R3=0x33, IR=0x2B, S=0110, M=0, CIN=0, LDC, LDZ, no DRW → Z=1, C=1, registers unchanged. Then S=1111, M=1, LDC → C stays 1.
- PC=0x10, IR low nibble 0xE, PCADD=1, PCINC=1 → PC=0x0F. Then LPC with ABUS F=0x80 and PCINC=1 → PC=0x80.
- AR=0x40, R1=0x77, IR=0x61, S=1010, M=1, ABUS, MEMW, LIR, I_RDATA=0x5B → D_WE=1, D_ADDR=0x40, D_WDATA=0x77; after the edge IR=0101. Next cycle SBUS+MBUS → DBUS=D_RDATA, BUS_ERR=1 until CLR.

Source files
------------

// File: rtl/tec8_pkg.sv
// ============================================================================
// tec8_pkg : shared constants, ALU function codes and DBUS source priority
//            for the TEC-8 datapath.
// Revision  : 1.0
// ============================================================================
`default_nettype none

package tec8_pkg;

   // Datapath / address width.
   localparam int DW = 8;

   // 74181 S-codes used by the controller (S_SUB and S_XOR share 0110:
   // arithmetic vs. logic is chosen by M).
   localparam logic [3:0] S_ADD   = 4'b1001;
   localparam logic [3:0] S_SUB   = 4'b0110;
   localparam logic [3:0] S_PASSB = 4'b1010;
   localparam logic [3:0] S_AND   = 4'b1011;
   localparam logic [3:0] S_OR    = 4'b1110;
   localparam logic [3:0] S_XOR   = 4'b0110;
   localparam logic [3:0] S_PASSA = 4'b1111;

   // DBUS driver chosen for the current cycle.
   typedef enum logic [1:0] {
      SRC_NONE = 2'd0,
      SRC_MEM  = 2'd1,
      SRC_ALU  = 2'd2,
      SRC_SW   = 2'd3
   } dbus_src_e;

   // Memory read data outranks the ALU, which outranks the switches.
   function automatic dbus_src_e dbus_src(input logic mbus, input logic abus,
                                          input logic sbus);
      dbus_src_e src;
      src = SRC_NONE;
      if (mbus)      src = SRC_MEM;
      else if (abus) src = SRC_ALU;
      else if (sbus) src = SRC_SW;
      return src;
   endfunction

endpackage

`default_nettype wire

// File: rtl/tec8_alu181.sv
// ============================================================================
// tec8_alu181 : combinational 74181-style ALU, active-high data convention.
//               Arithmetic mode forms x + y + cin on DW+1 bits so the top
//               bit is the carry; logic mode passes the current C through.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tec8_alu181
   import tec8_pkg::*;
#(
   parameter int DW = tec8_pkg::DW
) (
   input  logic [DW-1:0] A_i,
   input  logic [DW-1:0] B_i,
   input  logic [3:0]    S_i,
   input  logic          M_i,
   input  logic          CIN_i,   // active-low: 0 adds +1
   input  logic          C_i,     // current carry flag
   output logic [DW-1:0] F_o,
   output logic          CO_o
);

   logic [DW:0]   x;
   logic [DW:0]   y;
   logic [DW:0]   sum;
   logic [DW-1:0] lf;
   logic [DW-1:0] nb;
   logic [DW:0]   ones;

   assign nb   = ~B_i;
   assign ones = {1'b0, {DW{1'b1}}};

   // Arithmetic operand pair; "minus one" terms are an all-ones addend.
   always_comb begin
      x = '0;
      y = '0;
      case (S_i)
         4'b0000: begin x = {1'b0, A_i};        y = '0;                   end
         4'b0001: begin x = {1'b0, A_i | B_i};  y = '0;                   end
         4'b0010: begin x = {1'b0, A_i | nb};   y = '0;                   end
         4'b0011: begin x = '0;                 y = ones;                 end
         4'b0100: begin x = {1'b0, A_i};        y = {1'b0, A_i & nb};     end
         4'b0101: begin x = {1'b0, A_i | B_i};  y = {1'b0, A_i & nb};     end
         S_SUB:   begin x = {1'b0, A_i};        y = {1'b0, nb};           end
         4'b0111: begin x = {1'b0, A_i & nb};   y = ones;                 end
         4'b1000: begin x = {1'b0, A_i};        y = {1'b0, A_i & B_i};    end
         S_ADD:   begin x = {1'b0, A_i};        y = {1'b0, B_i};          end
         4'b1010: begin x = {1'b0, A_i | nb};   y = {1'b0, A_i & B_i};    end
         4'b1011: begin x = {1'b0, A_i & B_i};  y = ones;                 end
         4'b1100: begin x = {1'b0, A_i};        y = {1'b0, A_i};          end
         4'b1101: begin x = {1'b0, A_i | B_i};  y = {1'b0, A_i};          end
         4'b1110: begin x = {1'b0, A_i | nb};   y = {1'b0, A_i};          end
         default: begin x = {1'b0, A_i};        y = ones;                 end
      endcase
   end

   assign sum = x + y + {{DW{1'b0}}, ~CIN_i};

   // Logic-mode function table.
   always_comb begin
      lf = '0;
      case (S_i)
         4'b0000: lf = ~A_i;
         4'b0001: lf = ~(A_i | B_i);
         4'b0010: lf = ~A_i & B_i;
         4'b0011: lf = '0;
         4'b0100: lf = ~(A_i & B_i);
         4'b0101: lf = nb;
         S_XOR:   lf = A_i ^ B_i;
         4'b0111: lf = A_i & nb;
         4'b1000: lf = ~A_i | B_i;
         4'b1001: lf = ~(A_i ^ B_i);
         S_PASSB: lf = B_i;
         S_AND:   lf = A_i & B_i;
         4'b1100: lf = '1;
         4'b1101: lf = A_i | nb;
         S_OR:    lf = A_i | B_i;
         default: lf = A_i;
      endcase
   end

   assign F_o  = M_i ? lf  : sum[DW-1:0];
   assign CO_o = M_i ? C_i : sum[DW];

endmodule

`default_nettype wire

// File: rtl/tec8_datapath.sv
// ============================================================================
// tec8_datapath : TEC-8 datapath - register file, PC, AR, IR, C/Z flags,
//                 ALU and the internal data bus. State advances on T3 rise.
// Revision      : 1.0
// ============================================================================
`default_nettype none

module tec8_datapath
   import tec8_pkg::*;
#(
   parameter int DW   = tec8_pkg::DW,
   parameter int NREG = 4
) (
   input  logic          T3,
   input  logic          CLR,
   input  logic [3:0]    SEL,
   input  logic          SELCTL,
   input  logic [3:0]    S,
   input  logic          M,
   input  logic          CIN,
   input  logic          ABUS,
   input  logic          SBUS,
   input  logic          MBUS,
   input  logic          DRW,
   input  logic          LPC,
   input  logic          PCINC,
   input  logic          PCADD,
   input  logic          LAR,
   input  logic          ARINC,
   input  logic          LIR,
   input  logic          LDC,
   input  logic          LDZ,
   input  logic          MEMW,
   input  logic [DW-1:0] SD,
   input  logic [DW-1:0] I_RDATA,
   input  logic [DW-1:0] D_RDATA,
   output logic [3:0]    IR,
   output logic          C,
   output logic          Z,
   output logic [DW-1:0] I_ADDR,
   output logic [DW-1:0] D_ADDR,
   output logic [DW-1:0] D_WDATA,
   output logic          D_WE,
   output logic [DW-1:0] DBUS,
   output logic [DW-1:0] PC_Q,
   output logic [DW-1:0] AR_Q,
   output logic [4*DW-1:0] REGS,
   output logic          BUS_ERR
);

   logic [DW-1:0] regs_q [NREG];
   logic [DW-1:0] pc_q,  pc_d;
   logic [DW-1:0] ar_q,  ar_d;
   logic [DW-1:0] ir_q,  ir_d;
   logic          c_q,   c_d;
   logic          z_q,   z_d;
   logic          err_q, err_d;

   logic [1:0]    rd;
   logic [1:0]    rs;
   logic [DW-1:0] alu_f;
   logic          alu_co;
   logic [DW-1:0] bus;
   logic [DW-1:0] pc_off;

   assign rd = SELCTL ? SEL[3:2] : ir_q[3:2];
   assign rs = SELCTL ? SEL[1:0] : ir_q[1:0];

   tec8_alu181 #(.DW(DW)) u_alu (
      .A_i   (regs_q[rd]),
      .B_i   (regs_q[rs]),
      .S_i   (S),
      .M_i   (M),
      .CIN_i (CIN),
      .C_i   (c_q),
      .F_o   (alu_f),
      .CO_o  (alu_co)
   );

   // Single-driver DBUS: pick the highest-priority enabled source.
   always_comb begin
      bus = '0;
      case (dbus_src(MBUS, ABUS, SBUS))
         SRC_MEM: bus = D_RDATA;
         SRC_ALU: bus = alu_f;
         SRC_SW:  bus = SD;
         default: bus = '0;
      endcase
   end

   // Next-state for PC, AR, IR, flags and the sticky bus-conflict flag.
   always_comb begin
      pc_off = PCADD ? {{(DW-4){ir_q[3]}}, ir_q[3:0]} : '0;
      pc_d   = LPC ? bus : pc_q + pc_off + {{(DW-1){1'b0}}, PCINC};
      ar_d   = LAR ? bus : (ARINC ? ar_q + 1'b1 : ar_q);
      ir_d   = LIR ? I_RDATA : ir_q;
      c_d    = LDC ? alu_co : c_q;
      z_d    = LDZ ? (alu_f == '0) : z_q;
      err_d  = err_q | (ABUS & SBUS) | (ABUS & MBUS) | (SBUS & MBUS);
   end

   // Control/flag register update.
   always_ff @(posedge T3 or negedge CLR) begin
      if (!CLR) begin
         pc_q  <= '0;
         ar_q  <= '0;
         ir_q  <= '0;
         c_q   <= 1'b0;
         z_q   <= 1'b0;
         err_q <= 1'b0;
      end else begin
         pc_q  <= pc_d;
         ar_q  <= ar_d;
         ir_q  <= ir_d;
         c_q   <= c_d;
         z_q   <= z_d;
         err_q <= err_d;
      end
   end

   // Register file write from DBUS into R[RD].
   always_ff @(posedge T3 or negedge CLR) begin
      if (!CLR) begin
         for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      end else if (DRW) begin
         regs_q[rd] <= bus;
      end
   end

   generate
      for (genvar g = 0; g < NREG; g++) begin : g_regs
         assign REGS[g*DW +: DW] = regs_q[g];
      end
   endgenerate

   assign IR      = ir_q[7:4];
   assign C       = c_q;
   assign Z       = z_q;
   assign I_ADDR  = pc_q;
   assign D_ADDR  = ar_q;
   assign D_WDATA = bus;
   assign D_WE    = MEMW;
   assign DBUS    = bus;
   assign PC_Q    = pc_q;
   assign AR_Q    = ar_q;
   assign BUS_ERR = err_q;

endmodule

`default_nettype wire
